// File: rtl/load_hash_if.sv
// Hash memory read port: the loader drives the read strobe and address,
// and the memory returns h_data one cycle after each strobe.
interface load_hash_if #(
  parameter int AW = 3
);
  logic          h_read;
  logic [AW-1:0] h_read_address;
  logic [31:0]   h_data;

  modport master (
    output h_read,
    output h_read_address,
    input  h_data
  );

  modport slave (
    input  h_read,
    input  h_read_address,
    output h_data
  );
endinterface

// File: rtl/load_hash.sv
// load_hash: reads HASH_LENGTH 32-bit words from hash memory and assembles
// them into hash_vector, word 0 in the least-significant position.
// Optional build macro LOAD_HASH_BYTE_SWAP_EN byte-reverses each word before
// placement. The cycle timing is the same with or without the macro.
//
// state | meaning
// IDLE  | after reset, waiting for start
// READ  | issuing one read per cycle, addresses 0..HASH_LENGTH-1
// DRAIN | capturing the word returned for the last address
// DONE  | hash_vector complete; hash_valid held until the next start
module load_hash #(
  parameter int HASH_LENGTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  load_hash_if.master                 mem,
  output logic [HASH_LENGTH*32-1:0]   hash_vector,
  output logic                        hash_valid,
  output logic                        busy
);

  localparam int AW = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(HASH_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic [AW-1:0]             cap_idx_q, cap_idx_d;
  logic [HASH_LENGTH*32-1:0] vec_q, vec_d;
  logic                      rd;
  logic [31:0]               word;

  // State, counter, capture flag and vector registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      cap_idx_q <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cap_idx_q <= cap_idx_d;
      vec_q     <= vec_d;
    end
  end

  // Next-state and read control. The counter returns to 0 on leaving READ
  // so it never wraps past the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        rd = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Optional byte reversal of the returned word.
  always_comb begin
`ifdef LOAD_HASH_BYTE_SWAP_EN
    word = {mem.h_data[7:0], mem.h_data[15:8], mem.h_data[23:16], mem.h_data[31:24]};
`else
    word = mem.h_data;
`endif
  end

  // Capture path: remember which address was read, then write its word into
  // the vector on the following cycle. Untouched words keep their old value.
  always_comb begin
    pend_d    = rd;
    cap_idx_d = cnt_q;
    vec_d     = vec_q;
    if (pend_q) begin
      vec_d[int'(cap_idx_q)*32 +: 32] = word;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    mem.h_read         = rd;
    mem.h_read_address = rd ? cnt_q : '0;
    busy               = (state_q == READ) || (state_q == DRAIN);
    hash_valid         = (state_q == DONE);
    hash_vector        = vec_q;
  end

endmodule
